alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_core.sv | 86 ++++++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state types shared by the ALU pipeline
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP      = 4'h0,
    OP_ADD      = 4'h1,
    OP_SUB      = 4'h2,
    OP_INC      = 4'h3,
    OP_DEC      = 4'h4,
    OP_OR       = 4'h5,
    OP_AND      = 4'h6,
    OP_XOR      = 4'h7,
    OP_SHR      = 4'h8,
    OP_SHL      = 4'h9,
    OP_ONESCOMP = 4'hA,
    OP_TWOSCOMP = 4'hB,
    OP_ADC      = 4'hC,
    OP_SBB      = 4'hD,
    OP_SHRN     = 4'hE,
    OP_SHLN     = 4'hF
  } opcode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_shift_n(input opcode_t op);
    return (op == OP_SHRN) || (op == OP_SHLN);
  endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath: result, carry/borrow and signed overflow
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] wide;
  logic [WIDTH:0] cin_w;

  assign cin_w = {{WIDTH{1'b0}}, carry_in};

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADC: begin
        wide   = {1'b0, a} + {1'b0, b} + cin_w;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      // Bit WIDTH of the wide difference is the borrow.
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SBB: begin
        wide   = {1'b0, a} - {1'b0, b} - cin_w;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        wide   = {1'b0, a} + ONE;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        ovf    = !a[WIDTH-1] && result[WIDTH-1];
      end
      OP_DEC: begin
        wide   = {1'b0, a} - ONE;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
        ovf    = a[WIDTH-1] && !result[WIDTH-1];
      end
      OP_OR:       result = a | b;
      OP_AND:      result = a & b;
      OP_XOR:      result = a ^ b;
      OP_SHR:      result = {1'b0, a[WIDTH-1:1]};
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_ONESCOMP: result = ~a;
      OP_TWOSCOMP: begin
        wide   = {1'b0, ~a} + ONE;
        result = wide[WIDTH-1:0];
        carry  = wide[WIDTH];
      end
      // Multi-bit shifts are sequenced by the pipeline; only a zero amount reaches here.
      OP_SHRN, OP_SHLN: result = a;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked ALU with registered result/flags and a bit-serial N-bit shifter
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_zero,
  output logic             alu_carry,
  output logic             alu_neg,
  output logic             alu_ovf
);

  localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           next_state;
  opcode_t          op;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] sh_data;
  logic             sh_left;
  logic             sh_last;
  logic             c_reg;
  logic             free;
  logic             load_core;
  logic             start_shift;
  logic             load_shift;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_ovf;
  logic [WIDTH-1:0] ld_val;
  logic             ld_carry;
  logic             ld_ovf;

  assign op   = opcode_t'(opcode);
  assign amt  = in_b[SHW-1:0];
  assign free = !out_valid || out_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (in_a),
    .b        (in_b),
    .op       (op),
    .carry_in (c_reg),
    .result   (core_result),
    .carry    (core_carry),
    .ovf      (core_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    in_ready    = 1'b0;
    load_core   = 1'b0;
    start_shift = 1'b0;
    load_shift  = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = free && !rst;
        if (in_valid && free && !rst) begin
          if (is_shift_n(op) && (amt != '0)) begin
            start_shift = 1'b1;
            next_state  = ST_SHIFT;
          end else begin
            load_core = 1'b1;
          end
        end
      end
      // Finished shifts wait here until the previous result has been taken.
      ST_SHIFT: begin
        if ((cnt == '0) && free) begin
          load_shift = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign ld_val   = load_shift ? sh_data : core_result;
  assign ld_carry = load_shift ? sh_last : core_carry;
  assign ld_ovf   = load_shift ? 1'b0    : core_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      alu_zero  <= 1'b0;
      alu_carry <= 1'b0;
      alu_neg   <= 1'b0;
      alu_ovf   <= 1'b0;
      c_reg     <= 1'b0;
    end else if (load_core || load_shift) begin
      out_valid <= 1'b1;
      alu_out   <= ld_val;
      alu_zero  <= (ld_val == '0);
      alu_carry <= ld_carry;
      alu_neg   <= ld_val[WIDTH-1];
      alu_ovf   <= ld_ovf;
      c_reg     <= ld_carry;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sh_data <= '0;
      sh_left <= 1'b0;
      sh_last <= 1'b0;
    end else if (start_shift) begin
      cnt     <= amt;
      sh_data <= in_a;
      sh_left <= (op == OP_SHLN);
      sh_last <= 1'b0;
    end else if ((state == ST_SHIFT) && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
      if (sh_left) begin
        sh_data <= {sh_data[WIDTH-2:0], 1'b0};
        sh_last <= sh_data[WIDTH-1];
      end else begin
        sh_data <= {1'b0, sh_data[WIDTH-1:1]};
        sh_last <= sh_data[0];
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - randomized and directed self-checking bench for alu_pipe
module tb_alu_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] opcode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_neg;
  logic       alu_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_neg   (alu_neg),
    .alu_ovf   (alu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic, signed overflow as an out-of-range true result.
  function automatic logic [9:0] ref_op(input int op, input int a, input int b, input int cin);
    int r, s, n, sa, sb;
    bit c, v;
    c  = 0;
    v  = 0;
    r  = 0;
    s  = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    n  = b % 8;
    case (op)
      1:  begin r = a + b;       c = r > 255; s = sa + sb;       v = (s > 127) || (s < -128); end
      2:  begin r = a - b;       c = r < 0;   s = sa - sb;       v = (s > 127) || (s < -128); end
      3:  begin r = a + 1;       c = r > 255; s = sa + 1;        v = s > 127;                 end
      4:  begin r = a - 1;       c = r < 0;   s = sa - 1;        v = s < -128;                end
      5:  r = a | b;
      6:  r = a & b;
      7:  r = a ^ b;
      8:  r = a / 2;
      9:  begin r = a * 2;       c = a >= 128; end
      10: r = 255 - a;
      11: begin r = (255 - a) + 1; c = r > 255; end
      12: begin r = a + b + cin; c = r > 255; s = sa + sb + cin; v = (s > 127) || (s < -128); end
      13: begin r = a - b - cin; c = r < 0;   s = sa - sb - cin; v = (s > 127) || (s < -128); end
      14: begin r = a >> n; c = (n > 0) ? ((a >> (n - 1)) & 1) != 0 : 0; end
      15: begin r = a << n; c = (n > 0) ? ((a >> (8 - n)) & 1) != 0 : 0; end
      default: r = 0;
    endcase
    return {v, c, r[7:0]};
  endfunction

  logic       m_ov, m_z, m_c, m_n, m_v, m_creg;
  logic [7:0] m_res;
  logic [9:0] m_pend;
  int         m_busy;

  // Compare process: settles after the driver, checks, then advances the model one edge.
  always @(negedge clk) begin
    logic       exp_ready;
    logic       load;
    logic [9:0] r;
    #2;
    if (rst) begin
      m_ov = 0; m_res = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0; m_creg = 0; m_busy = 0; m_pend = 0;
    end
    exp_ready = !rst && (m_busy == 0) && (!m_ov || out_ready);
    check("out_valid", out_valid, m_ov);
    check("alu_out",   alu_out,   m_res);
    check("alu_zero",  alu_zero,  m_z);
    check("alu_carry", alu_carry, m_c);
    check("alu_neg",   alu_neg,   m_n);
    check("alu_ovf",   alu_ovf,   m_v);
    check("in_ready",  in_ready,  exp_ready);
    if (!rst) begin
      load = 0;
      r    = '0;
      if (m_busy > 1) begin
        m_busy--;
      end else if (m_busy == 1) begin
        if (!m_ov || out_ready) begin
          r = m_pend; load = 1; m_busy = 0;
        end
      end else if (in_valid && exp_ready) begin
        if ((opcode >= 4'hE) && (in_b[2:0] != 0)) begin
          m_pend = ref_op(opcode, in_a, in_b, 0);
          m_busy = in_b[2:0] + 1;
        end else begin
          r = ref_op(opcode, in_a, in_b, m_creg); load = 1;
        end
      end
      if (load) begin
        m_ov = 1; m_res = r[7:0]; m_z = (r[7:0] == 0); m_n = r[7];
        m_c = r[8]; m_v = r[9]; m_creg = r[8];
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic rdy);
    @(negedge clk);
    #1;
    in_valid = v; opcode = op; in_a = a; in_b = b; out_ready = rdy;
    #1;
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 5))
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h7F;
      3: return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1; in_valid = 0; opcode = 0; in_a = 0; in_b = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1 rst = 0;

    drive(1, 4'h1, 8'hFF, 8'h01, 1);
    check("add_ready", in_ready, 1);
    drive(1, 4'hC, 8'h10, 8'h20, 1);
    check("add_valid", out_valid, 1);
    check("add_out",   alu_out,   8'h00);
    check("add_carry", alu_carry, 1);
    check("add_zero",  alu_zero,  1);
    check("add_ovf",   alu_ovf,   0);
    drive(1, 4'h2, 8'h05, 8'h07, 1);
    check("adc_out",   alu_out,   8'h31);
    check("adc_carry", alu_carry, 0);
    drive(1, 4'h1, 8'h7F, 8'h01, 1);
    check("sub_out",   alu_out,   8'hFE);
    check("sub_carry", alu_carry, 1);
    check("sub_neg",   alu_neg,   1);
    drive(1, 4'hF, 8'h81, 8'h03, 1);
    check("ovf_out",   alu_out,   8'h80);
    check("ovf_flag",  alu_ovf,   1);
    for (int k = 0; k < 4; k++) begin
      drive(0, 4'h0, 8'h00, 8'h00, 1);
      check("shln_busy_ready", in_ready,  0);
      check("shln_busy_valid", out_valid, 0);
    end
    drive(0, 4'h0, 8'h00, 8'h00, 0);
    check("shln_valid", out_valid, 1);
    check("shln_out",   alu_out,   8'h08);
    check("shln_carry", alu_carry, 0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 4'h0, 8'h00, 8'h00, 0);
      check("hold_valid", out_valid, 1);
      check("hold_out",   alu_out,   8'h08);
      check("hold_ready", in_ready,  0);
    end
    drive(1, 4'h7, 8'h0F, 8'hF0, 1);
    check("drain_ready", in_ready, 1);
    drive(1, 4'hE, 8'hF0, 8'h05, 1);
    check("xor_out",   alu_out,   8'hFF);
    check("xor_valid", out_valid, 1);
    drive(0, 4'h0, 8'h00, 8'h00, 1);
    @(negedge clk);
    #1 rst = 1;
    #1;
    check("rst_out",   alu_out,   0);
    check("rst_valid", out_valid, 0);
    check("rst_flags", {alu_zero, alu_carry, alu_neg, alu_ovf}, 0);
    check("rst_ready", in_ready,  0);
    @(negedge clk);
    #1 rst = 0;
    for (int k = 0; k < 8; k++) begin
      drive(0, 4'h0, 8'h00, 8'h00, 1);
      check("no_result", out_valid, 0);
    end
    drive(1, 4'h1, 8'h01, 8'h02, 1);
    check("post_rst_ready", in_ready, 1);
    drive(0, 4'h0, 8'h00, 8'h00, 1);
    check("post_rst_out", alu_out, 8'h03);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, 4'($urandom), pick(), pick(), $urandom_range(0, 9) < 7);
    end
    repeat (12) drive(0, 4'h0, 8'h00, 8'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
